wb_stage_p: RTL and testbench

Parametrised MEM/WB pipeline register and write-back unit for the pipelined MIPS core. Captures memory-stage results on each pipeline advance and drives the register-file write port: enable, destination and data. Adds bubble/valid tracking, sub-word load extraction with sign/zero extension, and sticky halt detection. Also provides a saturating retired-instruction counter and forces writes to $0 low.

---
 rtl/cpu_types_pkg.sv | 31 +++
 rtl/load_extend.sv | 33 +++
 rtl/wb_stage_p.sv | 149 ++++++++++++++
 tb/tb_wb_stage_p.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: result-select codes, load types and
// the write-back control state encoding.
package cpu_types_pkg;

    localparam int WORD_W   = 32;
    localparam int REGSEL_W = 2;
    localparam int LDTYPE_W = 3;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [REGSEL_W-1:0] {
        ALUr  = 2'd0,
        DLoad = 2'd1,
        Jal   = 2'd2,
        Lui   = 2'd3
    } regsel_t;

    typedef enum logic [LDTYPE_W-1:0] {
        LW  = 3'd0,
        LH  = 3'd1,
        LHU = 3'd2,
        LB  = 3'd3,
        LBU = 3'd4
    } ldtype_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } wb_state_t;

endpackage

// File: rtl/load_extend.sv
// Little-endian sub-word load extraction with sign/zero extension.
// Purely combinational; lane chosen by the low address bits.
module load_extend
    import cpu_types_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int LANE_AW = $clog2(DATA_W/8)
) (
    input  logic [DATA_W-1:0]   dmemload,
    input  logic [LDTYPE_W-1:0] ld_type,
    input  logic [LANE_AW-1:0]  addr_lo,
    output logic [DATA_W-1:0]   load_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Pick the addressed lane, then extend according to the load type;
    // unknown load codes fall through to a full-word pass-through.
    always_comb begin
        byte_lane = 8'(dmemload >> {addr_lo, 3'b000});
        half_lane = 16'(dmemload >> {addr_lo[LANE_AW-1:1], 4'b0000});
        load_data = dmemload;
        case (ldtype_t'(ld_type))
            LB:      load_data = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
            LBU:     load_data = {{(DATA_W-8){1'b0}}, byte_lane};
            LH:      load_data = {{(DATA_W-16){half_lane[15]}}, half_lane};
            LHU:     load_data = {{(DATA_W-16){1'b0}}, half_lane};
            default: load_data = dmemload;
        endcase
    end

endmodule

// File: rtl/wb_stage_p.sv
// MEM/WB pipeline register and write-back unit: holds one slot, drives
// the register-file write port, tracks a sticky halt and counts retires.
module wb_stage_p
    import cpu_types_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32,
    localparam int LANE_AW = $clog2(DATA_W/8)
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 en,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic                 in_regWr,
    input  logic [REG_AW-1:0]    in_regDst,
    input  logic [REGSEL_W-1:0]  in_regSel,
    input  logic [LDTYPE_W-1:0]  in_ldType,
    input  logic [LANE_AW-1:0]   in_addrLo,
    input  logic [DATA_W-1:0]    in_nPC,
    input  logic [DATA_W-1:0]    in_ALUOut,
    input  logic [DATA_W-1:0]    in_lui,
    input  logic [DATA_W-1:0]    in_dmemload,
    input  logic                 in_halt,
    output logic                 WEN,
    output logic [REG_AW-1:0]    wsel,
    output logic [DATA_W-1:0]    wdat,
    output logic                 halt,
    output logic [CNT_W-1:0]     retired
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic                slot_valid;
    logic                slot_reg_wr;
    logic [REG_AW-1:0]   slot_reg_dst;
    regsel_t             slot_reg_sel;
    logic [LDTYPE_W-1:0] slot_ld_type;
    logic [LANE_AW-1:0]  slot_addr_lo;
    logic [DATA_W-1:0]   slot_npc;
    logic [DATA_W-1:0]   slot_alu_out;
    logic [DATA_W-1:0]   slot_lui;
    logic [DATA_W-1:0]   slot_dmemload;
    logic                slot_halt;

    wb_state_t state, state_next;
    logic      halted;
    logic      count_en;
    logic [DATA_W-1:0] load_data;

    assign halted   = (state == HALTED);
    assign count_en = en & ~flush & ~halted & in_valid;

    // Slot register: flush beats the halt freeze, which beats capture.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            slot_valid    <= 1'b0;
            slot_reg_wr   <= 1'b0;
            slot_reg_dst  <= '0;
            slot_reg_sel  <= ALUr;
            slot_ld_type  <= '0;
            slot_addr_lo  <= '0;
            slot_npc      <= '0;
            slot_alu_out  <= '0;
            slot_lui      <= '0;
            slot_dmemload <= '0;
            slot_halt     <= 1'b0;
        end else if (flush) begin
            slot_valid    <= 1'b0;
            slot_reg_wr   <= 1'b0;
            slot_reg_dst  <= '0;
            slot_reg_sel  <= ALUr;
            slot_ld_type  <= '0;
            slot_addr_lo  <= '0;
            slot_npc      <= '0;
            slot_alu_out  <= '0;
            slot_lui      <= '0;
            slot_dmemload <= '0;
            slot_halt     <= 1'b0;
        end else if (halted) begin
            slot_valid    <= slot_valid;
        end else if (en) begin
            slot_valid    <= in_valid;
            slot_reg_wr   <= in_regWr;
            slot_reg_dst  <= in_regDst;
            slot_reg_sel  <= regsel_t'(in_regSel);
            slot_ld_type  <= in_ldType;
            slot_addr_lo  <= in_addrLo;
            slot_npc      <= in_nPC;
            slot_alu_out  <= in_ALUOut;
            slot_lui      <= in_lui;
            slot_dmemload <= in_dmemload;
            slot_halt     <= in_halt;
        end
    end

    // Control state register; only reset leaves HALTED.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Enter HALTED once a valid HALT has occupied the slot for a cycle.
    always_comb begin
        state_next = state;
        if (state == RUN && slot_valid && slot_halt) begin
            state_next = HALTED;
        end
    end

    // Saturating count of valid instructions accepted into the slot.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            retired <= '0;
        end else if (count_en && (retired != {CNT_W{1'b1}})) begin
            retired <= retired + CNT_ONE;
        end
    end

    load_extend #(
        .DATA_W (DATA_W)
    ) u_load_extend (
        .dmemload  (slot_dmemload),
        .ld_type   (slot_ld_type),
        .addr_lo   (slot_addr_lo),
        .load_data (load_data)
    );

    // Write data is chosen from registered state only, so no in_* path.
    always_comb begin
        wdat = slot_alu_out;
        case (slot_reg_sel)
            ALUr:    wdat = slot_alu_out;
            DLoad:   wdat = load_data;
            Jal:     wdat = slot_npc;
            Lui:     wdat = slot_lui;
            default: wdat = slot_alu_out;
        endcase
    end

    assign WEN  = slot_valid & slot_reg_wr & (slot_reg_dst != '0) & ~halted;
    assign wsel = slot_reg_dst;
    assign halt = halted;

endmodule

// File: tb/tb_wb_stage_p.sv
// Testbench for wb_stage_p: directed vector table, halt/reset sequences,
// then randomized traffic checked against a cycle-level reference model.
module tb_wb_stage_p;

    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;
    localparam logic [31:0] DMEM = 32'h80FF7F01;

    typedef struct packed {
        logic        en;
        logic        flush;
        logic        valid;
        logic        reg_wr;
        logic [4:0]  dst;
        logic [1:0]  sel;
        logic [2:0]  ld;
        logic [1:0]  addr;
        logic [31:0] npc;
        logic [31:0] alu;
        logic [31:0] lui;
        logic [31:0] dmem;
        logic        halt;
    } stim_t;

    typedef struct packed {
        stim_t       s;
        logic        e_wen;
        logic [4:0]  e_wsel;
        logic [31:0] e_wdat;
        logic [3:0]  e_ret;
    } vec_t;

    logic        CLK;
    logic        nRST;
    logic        en, flush, in_valid, in_regWr, in_halt;
    logic [4:0]  in_regDst;
    logic [1:0]  in_regSel;
    logic [2:0]  in_ldType;
    logic [1:0]  in_addrLo;
    logic [31:0] in_nPC, in_ALUOut, in_lui, in_dmemload;
    logic        WEN;
    logic [4:0]  wsel;
    logic [31:0] wdat;
    logic        halt;
    logic [3:0]  retired;

    int check_count = 0;
    int pass_count  = 0;

    stim_t m_slot;
    logic  m_halted;
    int    m_count;

    wb_stage_p #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .CNT_W  (CNT_W)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .en          (en),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_regWr    (in_regWr),
        .in_regDst   (in_regDst),
        .in_regSel   (in_regSel),
        .in_ldType   (in_ldType),
        .in_addrLo   (in_addrLo),
        .in_nPC      (in_nPC),
        .in_ALUOut   (in_ALUOut),
        .in_lui      (in_lui),
        .in_dmemload (in_dmemload),
        .in_halt     (in_halt),
        .WEN         (WEN),
        .wsel        (wsel),
        .wdat        (wdat),
        .halt        (halt),
        .retired     (retired)
    );

    // Free-running clock, period 10.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic stim_t st(input logic e, input logic f, input logic v, input logic w,
                                 input logic [4:0] d, input logic [1:0] sel, input logic [2:0] ld,
                                 input logic [1:0] a, input logic [31:0] npc, input logic [31:0] alu,
                                 input logic [31:0] lui, input logic [31:0] dmem, input logic h);
        stim_t s;
        s.en = e; s.flush = f; s.valid = v; s.reg_wr = w; s.dst = d; s.sel = sel;
        s.ld = ld; s.addr = a; s.npc = npc; s.alu = alu; s.lui = lui; s.dmem = dmem; s.halt = h;
        return s;
    endfunction

    function automatic stim_t alu_st(input logic [4:0] d, input logic [31:0] alu);
        return st(1'b1, 1'b0, 1'b1, 1'b1, d, 2'd0, 3'd0, 2'd0, 32'h0, alu, 32'h0, 32'h0, 1'b0);
    endfunction

    function automatic stim_t ld_st(input logic [4:0] d, input logic [2:0] ld, input logic [1:0] a);
        return st(1'b1, 1'b0, 1'b1, 1'b1, d, 2'd1, ld, a, 32'h0, 32'h0, 32'h0, DMEM, 1'b0);
    endfunction

    function automatic vec_t vec(input stim_t s, input logic w, input logic [4:0] ws,
                                 input logic [31:0] wd, input logic [3:0] r);
        vec_t v;
        v.s = s; v.e_wen = w; v.e_wsel = ws; v.e_wdat = wd; v.e_ret = r;
        return v;
    endfunction

    // Write data the instruction in a slot should produce, from the ISA rules.
    function automatic logic [31:0] ref_wdat(input stim_t s);
        int b, h;
        b = int'((s.dmem >> (8 * s.addr)) % 256);
        h = int'((s.dmem >> (16 * (s.addr / 2))) % 65536);
        case (s.sel)
            2'd0: return s.alu;
            2'd2: return s.npc;
            2'd3: return s.lui;
            default: begin
                case (s.ld)
                    3'd1:    return 32'(h >= 32768 ? h - 65536 : h);
                    3'd2:    return 32'(h);
                    3'd3:    return 32'(b >= 128 ? b - 256 : b);
                    3'd4:    return 32'(b);
                    default: return s.dmem;
                endcase
            end
        endcase
    endfunction

    task automatic model_reset();
        m_slot   = '0;
        m_halted = 1'b0;
        m_count  = 0;
    endtask

    // One rising edge of the reference model, all decisions on old state.
    task automatic model_edge(input stim_t s);
        logic reach_halt;
        reach_halt = m_slot.valid && m_slot.halt;
        if (s.en && !s.flush && !m_halted && s.valid && m_count < CNT_MAX) m_count++;
        if (s.flush) m_slot = '0;
        else if (!m_halted && s.en) m_slot = s;
        if (reach_halt) m_halted = 1'b1;
    endtask

    task automatic drive(input stim_t s);
        en = s.en; flush = s.flush; in_valid = s.valid; in_regWr = s.reg_wr;
        in_regDst = s.dst; in_regSel = s.sel; in_ldType = s.ld; in_addrLo = s.addr;
        in_nPC = s.npc; in_ALUOut = s.alu; in_lui = s.lui; in_dmemload = s.dmem;
        in_halt = s.halt;
    endtask

    task automatic compare(input string tag, input string field,
                           input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("[TB] FAIL %s.%s actual=%h required=%h", tag, field, act, exp);
    endtask

    task automatic checkOutput(input string tag, input logic e_wen, input logic [4:0] e_wsel,
                               input logic [31:0] e_wdat, input logic e_halt, input logic [3:0] e_ret);
        compare(tag, "WEN",     32'(WEN),     32'(e_wen));
        compare(tag, "wsel",    32'(wsel),    32'(e_wsel));
        compare(tag, "wdat",    wdat,         e_wdat);
        compare(tag, "halt",    32'(halt),    32'(e_halt));
        compare(tag, "retired", 32'(retired), 32'(e_ret));
    endtask

    task automatic checkModel(input string tag);
        checkOutput(tag, m_slot.valid && m_slot.reg_wr && (m_slot.dst != 5'd0) && !m_halted,
                    m_slot.dst, ref_wdat(m_slot), m_halted, 4'(m_count));
    endtask

    // Called just after a falling edge: drive, step the model, cross one rising edge.
    task automatic applyStimulus(input stim_t s);
        drive(s);
        model_edge(s);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic doReset(input string tag);
        nRST = 1'b0;
        #1;
        checkOutput(tag, 1'b0, 5'd0, 32'h0, 1'b0, 4'd0);
        @(negedge CLK);
        nRST = 1'b1;
        model_reset();
    endtask

    initial begin
        vec_t  vecs[$];
        stim_t idle;
        stim_t rs;
        int    halted_cycles;

        idle = '0;
        drive(idle);
        model_reset();
        nRST = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        checkOutput("reset", 1'b0, 5'd0, 32'h0, 1'b0, 4'd0);
        nRST = 1'b1;

        vecs.push_back(vec(alu_st(5'd5, 32'h1234),                   1'b1, 5'd5,  32'h00001234, 4'd1));
        vecs.push_back(vec(ld_st(5'd6, 3'd3, 2'd3),                  1'b1, 5'd6,  32'hFFFFFF80, 4'd2));
        vecs.push_back(vec(ld_st(5'd7, 3'd4, 2'd1),                  1'b1, 5'd7,  32'h0000007F, 4'd3));
        vecs.push_back(vec(ld_st(5'd8, 3'd1, 2'd2),                  1'b1, 5'd8,  32'hFFFF80FF, 4'd4));
        vecs.push_back(vec(ld_st(5'd9, 3'd2, 2'd0),                  1'b1, 5'd9,  32'h00007F01, 4'd5));
        vecs.push_back(vec(st(1'b0, 1'b0, 1'b1, 1'b1, 5'd10, 2'd0, 3'd0, 2'd0, 32'h0, 32'hDEAD, 32'h0, 32'h0, 1'b0),
                                                                     1'b1, 5'd9,  32'h00007F01, 4'd5));
        vecs.push_back(vec(st(1'b1, 1'b1, 1'b1, 1'b1, 5'd11, 2'd0, 3'd0, 2'd0, 32'h0, 32'hBEEF, 32'h0, 32'h0, 1'b0),
                                                                     1'b0, 5'd0,  32'h00000000, 4'd5));
        vecs.push_back(vec(alu_st(5'd0, 32'h55),                     1'b0, 5'd0,  32'h00000055, 4'd6));
        vecs.push_back(vec(st(1'b1, 1'b0, 1'b0, 1'b1, 5'd12, 2'd0, 3'd0, 2'd0, 32'h0, 32'h66, 32'h0, 32'h0, 1'b0),
                                                                     1'b0, 5'd12, 32'h00000066, 4'd6));
        vecs.push_back(vec(st(1'b1, 1'b0, 1'b1, 1'b1, 5'd31, 2'd2, 3'd0, 2'd0, 32'h400, 32'h999, 32'h0, 32'h0, 1'b0),
                                                                     1'b1, 5'd31, 32'h00000400, 4'd7));
        vecs.push_back(vec(st(1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 2'd3, 3'd0, 2'd0, 32'h0, 32'h999, 32'hABCD0000, 32'h0, 1'b0),
                                                                     1'b1, 5'd3,  32'hABCD0000, 4'd8));
        vecs.push_back(vec(ld_st(5'd4, 3'd0, 2'd2),                  1'b1, 5'd4,  32'h80FF7F01, 4'd9));
        vecs.push_back(vec(ld_st(5'd4, 3'd7, 2'd1),                  1'b1, 5'd4,  32'h80FF7F01, 4'd10));
        for (int i = 0; i < 6; i++) begin
            vecs.push_back(vec(alu_st(5'd1, 32'h101 + 32'(i)), 1'b1, 5'd1, 32'h101 + 32'(i),
                               (i < 5) ? 4'(11 + i) : 4'd15));
        end

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].s);
            checkOutput($sformatf("vec%0d", i), vecs[i].e_wen, vecs[i].e_wsel,
                        vecs[i].e_wdat, 1'b0, vecs[i].e_ret);
        end

        doReset("mid_run_reset");

        // HALT that also writes: its write happens, then halt rises one edge later.
        applyStimulus(st(1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 2'd0, 3'd0, 2'd0, 32'h0, 32'h77, 32'h0, 32'h0, 1'b1));
        checkOutput("halt_slot", 1'b1, 5'd2, 32'h77, 1'b0, 4'd1);
        applyStimulus(idle);
        checkOutput("halt_rise", 1'b0, 5'd2, 32'h77, 1'b1, 4'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(alu_st(5'd3, 32'h88));
            checkOutput($sformatf("halt_frozen%0d", i), 1'b0, 5'd2, 32'h77, 1'b1, 4'd1);
        end
        doReset("halt_reset");

        halted_cycles = 0;
        for (int i = 0; i < 400; i++) begin
            if (halted_cycles > 4 || $urandom_range(0, 79) == 0) begin
                doReset($sformatf("rnd_reset%0d", i));
                halted_cycles = 0;
            end
            rs.en     = ($urandom_range(0, 3) != 0);
            rs.flush  = ($urandom_range(0, 7) == 0);
            rs.valid  = ($urandom_range(0, 4) != 0);
            rs.reg_wr = ($urandom_range(0, 3) != 0);
            rs.dst    = 5'($urandom_range(0, 31));
            rs.sel    = 2'($urandom_range(0, 3));
            rs.ld     = 3'($urandom_range(0, 7));
            rs.addr   = 2'($urandom_range(0, 3));
            rs.npc    = $urandom;
            rs.alu    = $urandom;
            rs.lui    = $urandom;
            rs.dmem   = $urandom;
            rs.halt   = ($urandom_range(0, 29) == 0);
            applyStimulus(rs);
            checkModel($sformatf("rnd%0d", i));
            if (m_halted) halted_cycles++;
        end

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
